// File: rtl/random_pkg.sv
// random_pkg: shared types and constants for the random sample path
package random_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, WAIT = 2'b10} rsb_state_t;
  localparam int RAND_WIDTH = 16;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: circular sample store with head/tail pointers and occupancy count
module sample_fifo
  import random_pkg::*;
#(
  parameter int WIDTH = RAND_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq,
  input  logic [WIDTH-1:0]         enq_data,
  input  logic                     deq_rdy,
  output logic                     val,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic push, pop;
  assign val = count != '0;
  assign pop = val && deq_rdy;
  assign push = enq && (count != FULL || pop);
  assign head_data = mem[head];
  // storage write on an accepted enqueue; contents need no reset
  always_ff @(posedge clk)
    if (push) mem[tail] <= enq_data;
  // pointers wrap naturally at DEPTH; a simultaneous push/pop keeps count
  always_ff @(posedge clk)
    if (!rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= push == pop ? count : push ? count + 1'b1 : count - 1'b1;
    end
endmodule

// File: rtl/random_sample_buffer.sv
// random_sample_buffer: requests engine samples one at a time and buffers them for a val/rdy consumer
module random_sample_buffer
  import random_pkg::*;
#(
  parameter int WIDTH = RAND_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   eng_go,
  input  logic                   eng_done_val,
  input  logic [WIDTH-1:0]       eng_rand,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [WIDTH-1:0]       out_msg,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  rsb_state_t state, state_n;
  logic capture;
  assign capture = state == WAIT && eng_done_val;
  assign eng_go = state == REQ;
  // space is only judged in IDLE, so a sample arriving in WAIT always fits
  always_comb
    state_n = state == IDLE ? (en && count < FULL ? REQ : IDLE) :
              state == REQ ? WAIT :
              state == WAIT && !eng_done_val ? WAIT : IDLE;
  // request sequencer
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // a done outside WAIT has no matching request and is flagged until reset
  always_ff @(posedge clk)
    if (!rst) err <= 1'b0;
    else if (eng_done_val && state != WAIT) err <= 1'b1;
  sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .enq(capture),
    .enq_data(eng_rand),
    .deq_rdy(out_rdy),
    .val(out_val),
    .head_data(out_msg),
    .count(count)
  );
endmodule

// File: tb/tb_random_sample_buffer.sv
// tb_random_sample_buffer: scoreboard bench with a fixed-latency engine model
`timescale 1ns/1ps
module tb_random_sample_buffer;
  localparam int W = 16;
  localparam int D = 4;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, out_rdy = 1'b0;
  logic model_done = 1'b0, spur_done = 1'b0;
  logic [W-1:0] model_val = '0, spur_val = '0, auto_val = 16'h1000;
  logic eng_go, eng_done_val, out_val, err;
  logic [W-1:0] eng_rand, out_msg;
  logic [2:0] count;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] vals[$];
  int checks = 0, passes = 0, pops = 0, timer = 0;

  assign eng_done_val = model_done | spur_done;
  assign eng_rand = spur_done ? spur_val : model_val;

  random_sample_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .eng_go(eng_go),
    .eng_done_val(eng_done_val),
    .eng_rand(eng_rand),
    .out_val(out_val),
    .out_rdy(out_rdy),
    .out_msg(out_msg),
    .count(count),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    model_done = 1'b0;
    if (!rst) timer = 0;
    else begin
      if (timer > 0) begin
        timer = timer - 1;
        if (timer == 0) begin
          model_done = 1'b1;
          if (vals.size() > 0) model_val = vals.pop_front();
          else begin
            model_val = auto_val;
            auto_val = auto_val + 16'd1;
          end
          exp_q.push_back(model_val);
        end
      end
      if (eng_go) timer = 3;
    end
  end

  always @(negedge clk)
    if (rst && out_val && out_rdy) begin
      checks++;
      if (exp_q.size() == 0) $display("FAIL sb_unexpected got %h want nothing", out_msg);
      else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out_msg !== e) $display("FAIL sb_data got %h want %h", out_msg, e);
        else passes++;
      end
      pops++;
    end

  task automatic drain();
    int n;
    n = 0;
    out_rdy = 1'b1;
    while (out_val && n < 40) begin step(); n++; end
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; out_rdy = 1'b0;
    repeat (3) step();
    checks++; if (eng_go !== 1'b0) $display("FAIL reset_go got %b want 0", eng_go); else passes++;
    checks++; if (out_val !== 1'b0) $display("FAIL reset_val got %b want 0", out_val); else passes++;
    checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passes++;
  endtask

  task automatic test_first();
    int n;
    n = 0;
    vals.push_back(16'hACE1);
    rst = 1'b1; en = 1'b1;
    step();
    checks++; if (eng_go !== 1'b1) $display("FAIL first_go got %b want 1", eng_go); else passes++;
    en = 1'b0;
    while (!out_val && n < 20) begin step(); n++; end
    checks++; if (n !== 4) $display("FAIL first_latency got %0d want 4", n); else passes++;
    checks++; if (out_msg !== 16'hACE1) $display("FAIL first_msg got %h want ace1", out_msg); else passes++;
    checks++; if (count !== 3'd1) $display("FAIL first_count got %0d want 1", count); else passes++;
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    checks++; if (count !== 3'd0) $display("FAIL first_drain got %0d want 0", count); else passes++;
  endtask

  task automatic test_fill();
    int gos, p0;
    gos = 0;
    for (int i = 1; i <= 4; i++) vals.push_back(W'(i));
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin step(); if (eng_go) gos++; end
    checks++; if (gos !== 4) $display("FAIL fill_gos got %0d want 4", gos); else passes++;
    checks++; if (count !== 3'd4) $display("FAIL fill_count got %0d want 4", count); else passes++;
    p0 = pops; gos = 0;
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin step(); if (eng_go) gos++; end
    out_rdy = 1'b0;
    checks++; if (pops - p0 !== 4) $display("FAIL fill_pops got %0d want 4", pops - p0); else passes++;
    for (int i = 0; i < 10; i++) begin step(); if (eng_go) gos++; end
    checks++; if (gos < 1) $display("FAIL fill_refill got %0d want >=1", gos); else passes++;
    en = 1'b0;
    repeat (10) step();
    drain();
    checks++; if (exp_q.size() !== 0) $display("FAIL fill_left got %0d want 0", exp_q.size()); else passes++;
  endtask

  task automatic test_wrap();
    int n, p0;
    n = 0;
    en = 1'b1; out_rdy = 1'b0;
    while (count !== 3'd4 && n < 60) begin step(); n++; end
    checks++; if (count !== 3'd4) $display("FAIL wrap_full got %0d want 4", count); else passes++;
    p0 = pops;
    out_rdy = 1'b1;
    step();
    checks++; if (eng_go !== 1'b0) $display("FAIL wrap_go_early got %b want 0", eng_go); else passes++;
    step();
    checks++; if (eng_go !== 1'b1) $display("FAIL wrap_go got %b want 1", eng_go); else passes++;
    repeat (80) step();
    en = 1'b0;
    repeat (10) step();
    drain();
    checks++; if (pops - p0 < 8) $display("FAIL wrap_pops got %0d want >=8", pops - p0); else passes++;
    checks++; if (exp_q.size() !== 0) $display("FAIL wrap_left got %0d want 0", exp_q.size()); else passes++;
  endtask

  task automatic test_simul();
    int n, gos;
    n = 0; gos = 0;
    en = 1'b1;
    while (gos < 2 && n < 40) begin step(); n++; if (eng_go) gos++; end
    en = 1'b0;
    n = 0;
    while (count !== 3'd2 && n < 20) begin step(); n++; end
    checks++; if (count !== 3'd2) $display("FAIL simul_setup got %0d want 2", count); else passes++;
    en = 1'b1;
    step();
    en = 1'b0;
    n = 0;
    while (!eng_done_val && n < 20) begin step(); n++; end
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    checks++; if (count !== 3'd2) $display("FAIL simul_count got %0d want 2", count); else passes++;
    checks++;
    if (exp_q.size() !== 2) $display("FAIL simul_depth got %0d want 2", exp_q.size());
    else if (out_msg !== exp_q[0]) $display("FAIL simul_head got %h want %h", out_msg, exp_q[0]);
    else passes++;
  endtask

  task automatic test_spurious();
    logic [2:0] c0;
    logic [W-1:0] m0;
    c0 = count; m0 = out_msg;
    checks++; if (err !== 1'b0) $display("FAIL spur_pre got %b want 0", err); else passes++;
    spur_val = 16'hDEAD; spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    step();
    checks++; if (err !== 1'b1) $display("FAIL spur_err got %b want 1", err); else passes++;
    checks++; if (count !== c0) $display("FAIL spur_count got %0d want %0d", count, c0); else passes++;
    checks++; if (out_msg !== m0) $display("FAIL spur_head got %h want %h", out_msg, m0); else passes++;
    repeat (5) step();
    checks++; if (err !== 1'b1) $display("FAIL spur_sticky got %b want 1", err); else passes++;
  endtask

  task automatic test_en_drop_reset();
    int n, gos;
    n = 0; gos = 0;
    en = 1'b1;
    while (!eng_go && n < 10) begin step(); n++; end
    checks++; if (eng_go !== 1'b1) $display("FAIL drop_go got %b want 1", eng_go); else passes++;
    step();
    en = 1'b0;
    n = 0;
    while (count !== 3'd3 && n < 20) begin step(); n++; end
    checks++; if (count !== 3'd3) $display("FAIL drop_count got %0d want 3", count); else passes++;
    repeat (10) begin step(); if (eng_go) gos++; end
    checks++; if (gos !== 0) $display("FAIL drop_nogo got %0d want 0", gos); else passes++;
    rst = 1'b0;
    step();
    checks++; if (count !== 3'd0) $display("FAIL rst_count got %0d want 0", count); else passes++;
    checks++; if (out_val !== 1'b0) $display("FAIL rst_val got %b want 0", out_val); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err); else passes++;
    checks++; if (eng_go !== 1'b0) $display("FAIL rst_go got %b want 0", eng_go); else passes++;
    exp_q.delete();
    vals.delete();
    rst = 1'b1; en = 1'b1;
    step();
    checks++; if (eng_go !== 1'b1) $display("FAIL rst_idle got %b want 1", eng_go); else passes++;
    en = 1'b0;
    repeat (10) step();
    drain();
    checks++; if (exp_q.size() !== 0) $display("FAIL rst_left got %0d want 0", exp_q.size()); else passes++;
  endtask

  initial begin
    test_reset();
    test_first();
    test_fill();
    test_wrap();
    test_simul();
    test_spurious();
    test_en_drop_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
